// File: rtl/icache_pkg.sv
// Shared widths, reset polarity and FSM encoding for the instruction cache.
package icache_pkg;
    localparam int AddrLen = 32;
    localparam int InstLen = 32;
    localparam logic [InstLen-1:0] ZEROWORD = '0;
    localparam logic ResetEnable = 1'b1;

    typedef enum logic [1:0] {
        IC_IDLE  = 2'd0,
        IC_MISS  = 2'd1,
        IC_DRAIN = 2'd2
    } ic_state_t;
endpackage

// File: rtl/icache_array.sv
// Direct-mapped line store: valid/tag/data, one synchronous write port, one combinational read port.
module icache_array
    import icache_pkg::*;
#(
    parameter int INDEX_W = 7,
    parameter int TAG_W   = 23,
    parameter int DATA_W  = InstLen
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_we,
    input  logic [INDEX_W-1:0] i_widx,
    input  logic [TAG_W-1:0]   i_wtag,
    input  logic [DATA_W-1:0]  i_wdata,
    input  logic [INDEX_W-1:0] i_ridx,
    output logic               o_rvalid,
    output logic [TAG_W-1:0]   o_rtag,
    output logic [DATA_W-1:0]  o_rdata
);
    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [DATA_W-1:0] r_data [LINES];

    always_ff @(posedge clk) begin
        if (rst == ResetEnable) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_widx] <= 1'b1;
        end
    end

    // Tag and data contents are meaningless until their valid bit is set, so they carry no reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag[i_widx]  <= i_wtag;
            r_data[i_widx] <= i_wdata;
        end
    end

    assign o_rvalid = r_valid[i_ridx];
    assign o_rtag   = r_tag[i_ridx];
    assign o_rdata  = r_data[i_ridx];
endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache between IF and mem_ctrl: 1-cycle hits, single-word line refill on miss.
// A flush during a refill lets the mem_ctrl read finish (DRAIN) so its byte sequencing is never cut short.
module icache
    import icache_pkg::*;
#(
    parameter int ADDR_W  = AddrLen,
    parameter int INST_W  = InstLen,
    parameter int INDEX_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_pc,
    output logic [INST_W-1:0] inst_o,
    output logic              inst_valid,
    output logic              ic_busy,
    output logic              mc_req,
    output logic [ADDR_W-1:0] mc_addr,
    input  logic [INST_W-1:0] mc_inst,
    input  logic              mc_valid,
    input  logic              mc_busy
);
    localparam int TAG_W = ADDR_W - INDEX_W - 2;

    ic_state_t           r_state;
    logic [ADDR_W-1:0]   r_mc_addr;
    logic [INST_W-1:0]   r_inst;
    logic                r_inst_valid;
    logic                r_mc_req;

    logic [INDEX_W-1:0]  w_rd_idx;
    logic [INDEX_W-1:0]  w_wr_idx;
    logic [TAG_W-1:0]    w_pc_tag;
    logic [TAG_W-1:0]    w_wr_tag;
    logic [TAG_W-1:0]    w_rd_tag;
    logic                w_rd_valid;
    logic [INST_W-1:0]   w_rd_data;
    logic                w_hit;
    logic                w_lookup;
    logic                w_fill;
    logic                w_unused;

    assign w_rd_idx = if_pc[INDEX_W+1:2];
    assign w_pc_tag = if_pc[ADDR_W-1:INDEX_W+2];
    assign w_wr_idx = r_mc_addr[INDEX_W+1:2];
    assign w_wr_tag = r_mc_addr[ADDR_W-1:INDEX_W+2];

    assign w_hit    = w_rd_valid && (w_rd_tag == w_pc_tag);
    assign w_lookup = (r_state == IC_IDLE) && if_req && !flush;
    // A returning word always fills, even when flushed: the data itself is correct.
    assign w_fill   = (r_state != IC_IDLE) && mc_valid;

    // mc_busy needs no action: mc_req/mc_addr are already frozen for the whole refill.
    assign w_unused = ^{if_pc[1:0], mc_busy};

    icache_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W),
        .DATA_W  (INST_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .i_we     (w_fill),
        .i_widx   (w_wr_idx),
        .i_wtag   (w_wr_tag),
        .i_wdata  (mc_inst),
        .i_ridx   (w_rd_idx),
        .o_rvalid (w_rd_valid),
        .o_rtag   (w_rd_tag),
        .o_rdata  (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst == ResetEnable) begin
            r_state      <= IC_IDLE;
            r_mc_addr    <= '0;
            r_mc_req     <= 1'b0;
            r_inst       <= ZEROWORD;
            r_inst_valid <= 1'b0;
        end else begin
            r_inst_valid <= 1'b0;
            case (r_state)
                IC_IDLE: begin
                    if (w_lookup) begin
                        if (w_hit) begin
                            r_inst       <= w_rd_data;
                            r_inst_valid <= 1'b1;
                        end else begin
                            r_mc_addr <= {if_pc[ADDR_W-1:2], 2'b00};
                            r_mc_req  <= 1'b1;
                            r_state   <= IC_MISS;
                        end
                    end
                end
                IC_MISS: begin
                    if (mc_valid) begin
                        r_mc_req <= 1'b0;
                        r_state  <= IC_IDLE;
                        if (!flush) begin
                            r_inst       <= mc_inst;
                            r_inst_valid <= 1'b1;
                        end
                    end else if (flush) begin
                        r_state <= IC_DRAIN;
                    end
                end
                IC_DRAIN: begin
                    if (mc_valid) begin
                        r_mc_req <= 1'b0;
                        r_state  <= IC_IDLE;
                    end
                end
                default: begin
                    r_mc_req <= 1'b0;
                    r_state  <= IC_IDLE;
                end
            endcase
        end
    end

    assign inst_o     = r_inst;
    assign inst_valid = r_inst_valid;
    assign ic_busy    = (r_state != IC_IDLE);
    assign mc_req     = r_mc_req;
    assign mc_addr    = r_mc_addr;
endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed sequences, a hit-vector table and randomized fetches vs. a line model.
module tb_icache;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_pc = '0;
    logic [31:0] inst_o;
    logic        inst_valid;
    logic        ic_busy;
    logic        mc_req;
    logic [31:0] mc_addr;
    logic [31:0] mc_inst = '0;
    logic        mc_valid = 1'b0;
    logic        mc_busy = 1'b0;

    int tests = 0;
    int fails = 0;

    // Reference: which word address each line currently holds.
    bit          m_valid [128];
    logic [29:0] m_line  [128];

    typedef struct {
        logic [31:0] pc;
        logic        fl;
        logic        ev;
    } vec_t;
    vec_t vt [7];

    icache dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .if_req     (if_req),
        .if_pc      (if_pc),
        .inst_o     (inst_o),
        .inst_valid (inst_valid),
        .ic_busy    (ic_busy),
        .mc_req     (mc_req),
        .mc_addr    (mc_addr),
        .mc_inst    (mc_inst),
        .mc_valid   (mc_valid),
        .mc_busy    (mc_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] pc);
        logic [31:0] a;
        a = {pc[31:2], 2'b00};
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One fetch; on a miss, mem_ctrl answers after lat wait cycles, with mc_busy for the first
    // busy_len of them and a flush on wait cycle flush_at (flush_at==lat: flush with mc_valid).
    task automatic fetch(input logic [31:0] pc, input int lat, input int flush_at, input int busy_len);
        int idx;
        bit exp_hit;
        bit flushed;
        idx = int'(pc[8:2]);
        exp_hit = m_valid[idx] && (m_line[idx] == pc[31:2]);
        flushed = (flush_at >= 0);
        if_req = 1'b1;
        if_pc = pc;
        step();
        if_req = 1'b0;
        if (exp_hit) begin
            chk("hit_valid", 32'(inst_valid), 32'd1);
            chk("hit_data", inst_o, memf(pc));
            chk("hit_mc_req", 32'(mc_req), 32'd0);
            chk("hit_busy", 32'(ic_busy), 32'd0);
        end else begin
            chk("miss_req", 32'(mc_req), 32'd1);
            chk("miss_addr", mc_addr, {pc[31:2], 2'b00});
            chk("miss_busy", 32'(ic_busy), 32'd1);
            for (int c = 0; c < lat; c++) begin
                mc_busy = (c < busy_len);
                flush = (c == flush_at);
                step();
                flush = 1'b0;
                chk("wait_req", 32'(mc_req), 32'd1);
                chk("wait_addr", mc_addr, {pc[31:2], 2'b00});
                chk("wait_valid", 32'(inst_valid), 32'd0);
            end
            mc_busy = 1'b0;
            flush = (flush_at == lat);
            mc_valid = 1'b1;
            mc_inst = memf(pc);
            step();
            mc_valid = 1'b0;
            flush = 1'b0;
            mc_inst = $urandom;
            chk("fill_valid", 32'(inst_valid), flushed ? 32'd0 : 32'd1);
            if (!flushed) chk("fill_data", inst_o, memf(pc));
            chk("fill_busy", 32'(ic_busy), 32'd0);
            chk("fill_req", 32'(mc_req), 32'd0);
            m_valid[idx] = 1'b1;
            m_line[idx] = pc[31:2];
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) m_valid[i] = 1'b0;

        vt[0] = '{pc: 32'h0000_0000, fl: 1'b0, ev: 1'b1};
        vt[1] = '{pc: 32'h0000_0004, fl: 1'b0, ev: 1'b1};
        vt[2] = '{pc: 32'h0000_0008, fl: 1'b0, ev: 1'b1};
        vt[3] = '{pc: 32'h0000_000C, fl: 1'b1, ev: 1'b0};
        vt[4] = '{pc: 32'h0000_000E, fl: 1'b0, ev: 1'b1};
        vt[5] = '{pc: 32'h0000_0001, fl: 1'b1, ev: 1'b0};
        vt[6] = '{pc: 32'h0000_0004, fl: 1'b0, ev: 1'b1};

        repeat (3) step();
        chk("rst_inst_o", inst_o, 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_mc_req", 32'(mc_req), 32'd0);
        chk("rst_mc_addr", mc_addr, 32'd0);
        chk("rst_ic_busy", 32'(ic_busy), 32'd0);
        rst = 1'b0;
        step();

        // Cold miss on 0x0 returning 0x13, then a hit.
        fetch(32'h0000_0000, 5, -1, 0);
        chk("cold_word_0x13", inst_o, 32'h0000_0013);
        fetch(32'h0000_0000, 5, -1, 0);

        // Same-index conflict evicts 0x0.
        fetch(32'h0000_0200, 6, -1, 0);
        fetch(32'h0000_0000, 5, -1, 0);

        // Flush two cycles into a miss, then refetch hits.
        fetch(32'h0000_0040, 6, 1, 0);
        fetch(32'h0000_0040, 5, -1, 0);

        // mc_busy held for 10 cycles of a refill.
        fetch(32'h0000_0080, 12, -1, 10);

        // Flush coincident with mc_valid.
        fetch(32'h0000_00C0, 5, 5, 0);
        fetch(32'h0000_00C0, 5, -1, 0);

        // Back-to-back hits with if_req held, including flush-in-IDLE entries.
        for (int i = 0; i < 4; i++) fetch(32'(i * 4), 5, -1, 0);
        for (int i = 0; i < 7; i++) begin
            if_req = 1'b1;
            if_pc = vt[i].pc;
            flush = vt[i].fl;
            step();
            chk("vec_valid", 32'(inst_valid), 32'(vt[i].ev));
            if (vt[i].ev) chk("vec_data", inst_o, memf(vt[i].pc));
            chk("vec_busy", 32'(ic_busy), 32'd0);
        end
        if_req = 1'b0;
        flush = 1'b0;
        step();

        // Reset during a refill drops it and clears every line.
        if_req = 1'b1;
        if_pc = 32'h0000_0100;
        step();
        if_req = 1'b0;
        chk("pre_rst_req", 32'(mc_req), 32'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_mc_req", 32'(mc_req), 32'd0);
        chk("midrst_busy", 32'(ic_busy), 32'd0);
        chk("midrst_addr", mc_addr, 32'd0);
        for (int i = 0; i < 128; i++) m_valid[i] = 1'b0;
        fetch(32'h0000_0000, 5, -1, 0);

        // Randomized fetches over a small address set to mix hits, conflicts and flushes.
        for (int n = 0; n < 200; n++) begin
            logic [31:0] pc;
            int lat;
            int fa;
            pc = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 7)) << 2)
                 | 32'($urandom_range(0, 3));
            lat = $urandom_range(5, 9);
            fa = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, lat)) : -1;
            fetch(pc, lat, fa, int'($urandom_range(0, lat)));
            if ($urandom_range(0, 3) == 0) begin
                mc_valid = 1'b1;
                mc_inst = $urandom;
                step();
                mc_valid = 1'b0;
                chk("idle_mcv_valid", 32'(inst_valid), 32'd0);
                chk("idle_mcv_busy", 32'(ic_busy), 32'd0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
